// File: rtl/pmi_pkg.sv
// Shared types and constants for the PMI memory responder.
package pmi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } pmi_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } pmi_op_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int          WORD_BYTES       = 4;

endpackage

// File: rtl/pmi_sram_array.sv
// Single-port synchronous 32-bit RAM; read-before-write, contents not reset.
module pmi_sram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);

  logic [31:0] mem [2**ADDR_W];

  // One access per cycle: optional write plus registered read of the same word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/pmi_mem_responder.sv
// Memory-side PMI responder: accepts held rd/wr strobes, waits a fixed number
// of cycles, performs the SRAM access and returns a one-cycle mfc pulse.
module pmi_mem_responder
  import pmi_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        mfc,
  output logic        err,
  output logic        busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  pmi_state_t        state;
  pmi_op_t           op_q;
  logic [ADDR_W-1:0] word_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [3:0]        cnt;

  logic              access_err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_dout;

  // Misaligned or beyond-depth addresses are flagged at acceptance time
  assign access_err = (address[1:0] != 2'b00) || (address[31:ADDR_W+2] != '0);

  // The RAM follows the live address while idle so a zero-wait read already
  // has its word registered by the completion edge; afterwards it follows the
  // latched word. No write can land between acceptance and completion.
  assign ram_addr = (state == IDLE) ? address[ADDR_W+1:2] : word_q;
  assign ram_we   = (state == BUSY) && (cnt == 4'd0) && (op_q == OP_WR) && !err_q;

  pmi_sram_array #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk (clk),
    .we  (ram_we),
    .addr(ram_addr),
    .din (wdata_q),
    .dout(ram_dout)
  );

  // Handshake FSM: latch request, count wait states, complete, pulse mfc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_RD;
      word_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= 4'd0;
      rd_data <= '0;
      mfc     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mfc <= 1'b0;
          err <= 1'b0;
          if (mem_rd || mem_wr) begin
            op_q    <= mem_wr ? OP_WR : OP_RD;
            word_q  <= address[ADDR_W+1:2];
            wdata_q <= wr_data;
            err_q   <= access_err;
            cnt     <= WAIT_LOAD;
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (op_q == OP_RD) begin
              rd_data <= err_q ? ERR_DATA : ram_dout;
            end
            mfc   <= 1'b1;
            err   <= err_q;
            state <= DONE;
          end
        end
        DONE: begin
          mfc   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmi_mem_responder.sv
// Directed bench for pmi_mem_responder: one instance with two wait states,
// one with zero wait states, driven from a vector table plus corner sequences.
module tb_pmi_mem_responder;

  localparam int          ADDR_W   = 10;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef struct {
    int          inst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd_data;
    logic        mfc;
    logic        err;
    logic        busy;
  } outs_t;

  logic clk = 1'b0;
  logic rst;

  logic        mem_rd_a, mem_wr_a, mfc_a, err_a, busy_a;
  logic [31:0] address_a, wr_data_a, rd_data_a;
  logic        mem_rd_b, mem_wr_b, mfc_b, err_b, busy_b;
  logic [31:0] address_b, wr_data_b, rd_data_b;

  int          vec_count  = 0;
  int          miss_count = 0;
  logic [31:0] last_rd [2];
  vec_t        vecs [16];

  always #5 clk = ~clk;

  pmi_mem_responder #(
    .ADDR_W(ADDR_W), .WAIT_CYCLES(2), .ERR_DATA(ERR_WORD)
  ) dut_a (
    .clk(clk), .rst(rst), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a),
    .address(address_a), .wr_data(wr_data_a), .rd_data(rd_data_a),
    .mfc(mfc_a), .err(err_a), .busy(busy_a)
  );

  pmi_mem_responder #(
    .ADDR_W(ADDR_W), .WAIT_CYCLES(0), .ERR_DATA(ERR_WORD)
  ) dut_b (
    .clk(clk), .rst(rst), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
    .address(address_b), .wr_data(wr_data_b), .rd_data(rd_data_b),
    .mfc(mfc_b), .err(err_b), .busy(busy_b)
  );

  task automatic driveReq(input int inst, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
    if (inst == 0) begin
      mem_rd_a = rd; mem_wr_a = wr; address_a = a; wr_data_a = d;
    end else begin
      mem_rd_b = rd; mem_wr_b = wr; address_b = a; wr_data_b = d;
    end
  endtask

  function automatic outs_t sampleOut(input int inst);
    outs_t o;
    if (inst == 0) begin
      o.rd_data = rd_data_a; o.mfc = mfc_a; o.err = err_a; o.busy = busy_a;
    end else begin
      o.rd_data = rd_data_b; o.mfc = mfc_b; o.err = err_b; o.busy = busy_b;
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Full transaction: assert strobes, track latency to mfc, release, check idle
  task automatic applyStimulus(input vec_t v);
    outs_t       o;
    bit          seen;
    int          wait_states;
    logic [31:0] exp_rd;
    seen        = 1'b0;
    wait_states = (v.inst == 0) ? 2 : 0;
    exp_rd      = (v.rd && !v.wr) ? v.exp_data : last_rd[v.inst];
    @(negedge clk);
    driveReq(v.inst, v.rd, v.wr, v.addr, v.wdata);
    @(posedge clk); #1;
    o = sampleOut(v.inst);
    checkOutput("busy after accept", 32'(o.busy), 32'd1);
    checkOutput("mfc at accept", 32'(o.mfc), 32'd0);
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk); #1;
      o = sampleOut(v.inst);
      if (o.mfc) begin
        seen = 1'b1;
        checkOutput("mfc latency", 32'(n), 32'(wait_states + 1));
        checkOutput("err with mfc", 32'(o.err), 32'(v.exp_err));
        checkOutput("busy in mfc cycle", 32'(o.busy), 32'd1);
        checkOutput("rd_data at completion", o.rd_data, exp_rd);
      end else begin
        checkOutput("rd_data held", o.rd_data, last_rd[v.inst]);
      end
    end
    if (!seen) checkOutput("mfc timeout", 32'd0, 32'd1);
    driveReq(v.inst, 1'b0, 1'b0, v.addr, v.wdata);
    @(posedge clk); #1;
    o = sampleOut(v.inst);
    checkOutput("mfc single pulse", 32'(o.mfc), 32'd0);
    checkOutput("err dropped", 32'(o.err), 32'd0);
    checkOutput("busy dropped", 32'(o.busy), 32'd0);
    checkOutput("rd_data after", o.rd_data, exp_rd);
    last_rd[v.inst] = exp_rd;
  endtask

  initial begin
    outs_t o;
    bit    seen;
    vec_t  tail;

    vecs[0]  = '{0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,          1'b0};
    vecs[1]  = '{0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'h1234_5678, 1'b0};
    vecs[2]  = '{1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0,          1'b0};
    vecs[3]  = '{1, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0002, 32'h0,          1'b0};
    vecs[4]  = '{1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0003, 32'h0,          1'b0};
    vecs[5]  = '{1, 1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h0000_0001, 1'b0};
    vecs[6]  = '{1, 1'b1, 1'b0, 32'h0000_0004, 32'h0,          32'h0000_0002, 1'b0};
    vecs[7]  = '{1, 1'b1, 1'b0, 32'h0000_0008, 32'h0,          32'h0000_0003, 1'b0};
    vecs[8]  = '{0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_1111, 32'h0,          1'b0};
    vecs[9]  = '{0, 1'b1, 1'b0, 32'h0000_0006, 32'h0,          ERR_WORD,      1'b1};
    vecs[10] = '{0, 1'b1, 1'b0, 32'h0000_1000, 32'h0,          ERR_WORD,      1'b1};
    vecs[11] = '{0, 1'b0, 1'b1, 32'h0000_1000, 32'h9999_9999, 32'h0,          1'b1};
    vecs[12] = '{0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h0000_1111, 1'b0};
    vecs[13] = '{0, 1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0,          1'b0};
    vecs[14] = '{0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'hA5A5_A5A5, 1'b0};
    vecs[15] = '{0, 1'b0, 1'b1, 32'h0000_0030, 32'h0000_3030, 32'h0,          1'b0};

    driveReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    driveReq(1, 1'b0, 1'b0, 32'h0, 32'h0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;

    // Reset state of both instances
    rst = 1'b1;
    #3;
    for (int i = 0; i < 2; i++) begin
      o = sampleOut(i);
      checkOutput("reset rd_data", o.rd_data, 32'h0);
      checkOutput("reset mfc", 32'(o.mfc), 32'd0);
      checkOutput("reset err", 32'(o.err), 32'd0);
      checkOutput("reset busy", 32'(o.busy), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
    end

    // Address and strobe changes after acceptance are ignored
    seen = 1'b0;
    @(negedge clk);
    driveReq(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    @(posedge clk); #1;
    driveReq(0, 1'b0, 1'b0, 32'h0000_0020, 32'hFFFF_0000);
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk); #1;
      o = sampleOut(0);
      if (o.mfc) begin
        seen = 1'b1;
        checkOutput("latched read latency", 32'(n), 32'd3);
        checkOutput("latched read data", o.rd_data, 32'h1234_5678);
        checkOutput("latched read err", 32'(o.err), 32'd0);
      end
    end
    if (!seen) checkOutput("latched read mfc timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    checkOutput("latched read mfc drop", 32'(mfc_a), 32'd0);
    last_rd[0] = 32'h1234_5678;

    // Reset one cycle before a write would commit
    @(negedge clk);
    driveReq(0, 1'b0, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("busy before reset", 32'(busy_a), 32'd1);
    rst = 1'b1;
    driveReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("mid reset busy", 32'(busy_a), 32'd0);
    checkOutput("mid reset rd_data", rd_data_a, 32'h0);
    checkOutput("mid reset mfc", 32'(mfc_a), 32'd0);
    @(posedge clk); #1;
    checkOutput("mid reset mfc at edge", 32'(mfc_a), 32'd0);
    rst = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      checkOutput("no mfc after reset", 32'(mfc_a), 32'd0);
    end
    tail = '{0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0000_3030, 1'b0};
    applyStimulus(tail);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
